uart_rx_port: RTL and testbench



---
 rtl/configure.sv | 24 ++
 rtl/uart_rx_fifo.sv | 69 ++++++
 rtl/uart_rx_port.sv | 265 ++++++++++++++++++++++++++
 tb/tb_uart_rx_port.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/configure.sv
// Shared SoC configuration package: clock/baud settings, buffer sizing,
// UART receiver address window, receiver FSM state type and register offsets.
package configure;

    // 25 MHz / 115200 baud
    localparam int clk_divider_bit = 217;
    localparam int buffer_depth    = 4;

    localparam logic [31:0] uart_rx_base_addr = 32'h0100_0010;
    localparam logic [31:0] uart_rx_irq_addr  = 32'h0100_0018;
    localparam logic [31:0] uart_rx_mask_addr = 32'h0000_000F;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        STOP      = 3'd3,
        WAIT_HIGH = 3'd4
    } uart_rx_state_t;

    localparam logic [3:0] UART_RX_DATA_OFS = 4'h0;
    localparam logic [3:0] UART_RX_CTRL_OFS = 4'h8;

endpackage

// File: rtl/uart_rx_fifo.sv
// Synchronous byte FIFO for the UART receiver. Occupancy count, full/empty
// flags; a push and pop in the same cycle both succeed even when full.
module uart_rx_fifo
    import configure::*;
#(
    parameter int DEPTH = buffer_depth
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push,
    input  logic [7:0]               push_data,
    input  logic                     pop,
    output logic [7:0]               pop_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [7:0]    mem_r [DEPTH];
    logic [AW-1:0] wptr_r;
    logic [AW-1:0] rptr_r;
    logic [CW-1:0] count_r;
    logic          do_push_s;
    logic          do_pop_s;

    assign full      = (count_r == CW'(DEPTH));
    assign empty     = (count_r == {CW{1'b0}});
    assign count     = count_r;
    assign pop_data  = mem_r[rptr_r];
    // A full FIFO still accepts a push when a pop frees a slot in the same cycle
    assign do_push_s = push && (!full || pop);
    assign do_pop_s  = pop && !empty;

    // Storage array write port
    always_ff @(posedge clock) begin
        if (do_push_s) begin
            mem_r[wptr_r] <= push_data;
        end
    end

    // Pointer and occupancy bookkeeping
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wptr_r  <= {AW{1'b0}};
            rptr_r  <= {AW{1'b0}};
            count_r <= {CW{1'b0}};
        end else begin
            if (do_push_s) begin
                wptr_r <= wptr_r + AW'(1);
            end else begin
                wptr_r <= wptr_r;
            end
            if (do_pop_s) begin
                rptr_r <= rptr_r + AW'(1);
            end else begin
                rptr_r <= rptr_r;
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/uart_rx_port.sv
// Memory-mapped 8N1 UART receiver. Offset 0x0 pops a received byte,
// offset 0x8 holds interrupt enable and status (ovr/ferr are W1C).
// Build option UART_RX_FIFO_EN: when defined, bytes are buffered in a
// DEPTH-entry FIFO; otherwise a single holding register is used.
module uart_rx_port
    import configure::*;
#(
    parameter int CLK_DIV = clk_divider_bit,
    parameter int DEPTH   = buffer_depth
) (
    input  logic        reset,
    input  logic        clock,
    input  logic        rx_valid,
    input  logic [31:0] rx_addr,
    input  logic [31:0] rx_wdata,
    input  logic [3:0]  rx_wstrb,
    output logic [31:0] rx_rdata,
    output logic        rx_ready,
    input  logic        uart_rx,
    output logic        rx_irq
);

    localparam int CNT_W = $clog2(CLK_DIV);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLK_DIV / 2 - 1);
    localparam logic [CNT_W-1:0] DIV_LAST  = CNT_W'(CLK_DIV - 1);

    logic [1:0]       sync_r;
    logic             line_s;
    uart_rx_state_t   state_r;
    logic [CNT_W-1:0] cnt_r;
    logic [2:0]       bit_idx_r;
    logic [7:0]       data_r;
    logic             push_s;
    logic             ferr_set_s;

    logic             ie_r;
    logic             ovr_r;
    logic             ferr_r;
    logic             full_s;
    logic             empty_s;
    logic [7:0]       head_s;
    logic [3:0]       count_field_s;

    logic [3:0]       offset_s;
    logic             is_read_s;
    logic             pop_s;
    logic             ctrl_wr_s;
    logic             ovr_set_s;
    logic [31:0]      rdata_next_s;

    // Bus bits that the register map never looks at
    logic unused_bits_s;
    assign unused_bits_s = ^{rx_addr[31:4], rx_wdata[31:4], rx_wdata[1], rx_wstrb[3:1]};

    assign line_s = sync_r[1];

    // Two-flop synchroniser for the asynchronous serial input
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync_r <= 2'b11;
        end else begin
            sync_r <= {sync_r[0], uart_rx};
        end
    end

    // The stop-bit sample decides between a push and a framing error
    assign push_s     = (state_r == STOP) && (cnt_r == DIV_LAST) && line_s;
    assign ferr_set_s = (state_r == STOP) && (cnt_r == DIV_LAST) && !line_s;

    // Receiver FSM: mid-bit sampling, LSB-first shift, stop-bit check
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r   <= IDLE;
            cnt_r     <= {CNT_W{1'b0}};
            bit_idx_r <= 3'd0;
            data_r    <= 8'h00;
        end else begin
            case (state_r)
                IDLE: begin
                    cnt_r <= {CNT_W{1'b0}};
                    if (!line_s) begin
                        state_r <= START;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                START: begin
                    if (cnt_r == HALF_LAST) begin
                        cnt_r <= {CNT_W{1'b0}};
                        if (line_s) begin
                            state_r <= IDLE;          // glitch, not a start bit
                        end else begin
                            state_r   <= DATA;
                            bit_idx_r <= 3'd0;
                        end
                    end else begin
                        cnt_r <= cnt_r + CNT_W'(1);
                    end
                end
                DATA: begin
                    if (cnt_r == DIV_LAST) begin
                        cnt_r  <= {CNT_W{1'b0}};
                        data_r <= {line_s, data_r[7:1]};
                        if (bit_idx_r == 3'd7) begin
                            state_r <= STOP;
                        end else begin
                            bit_idx_r <= bit_idx_r + 3'd1;
                        end
                    end else begin
                        cnt_r <= cnt_r + CNT_W'(1);
                    end
                end
                STOP: begin
                    if (cnt_r == DIV_LAST) begin
                        cnt_r <= {CNT_W{1'b0}};
                        if (line_s) begin
                            state_r <= IDLE;
                        end else begin
                            state_r <= WAIT_HIGH;     // break or framing error
                        end
                    end else begin
                        cnt_r <= cnt_r + CNT_W'(1);
                    end
                end
                WAIT_HIGH: begin
                    cnt_r <= {CNT_W{1'b0}};
                    if (line_s) begin
                        state_r <= IDLE;
                    end else begin
                        state_r <= WAIT_HIGH;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    cnt_r   <= {CNT_W{1'b0}};
                end
            endcase
        end
    end

`ifdef UART_RX_FIFO_EN
    logic [$clog2(DEPTH):0] fifo_count_s;

    uart_rx_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (push_s),
        .push_data (data_r),
        .pop       (pop_s),
        .pop_data  (head_s),
        .count     (fifo_count_s),
        .full      (full_s),
        .empty     (empty_s)
    );

    assign count_field_s = 4'(fifo_count_s);
`else
    logic [7:0] hold_data_r;
    logic       hold_full_r;

    // Single-entry holding register; a pop frees it for a same-cycle push
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            hold_data_r <= 8'h00;
            hold_full_r <= 1'b0;
        end else if (push_s && (!hold_full_r || pop_s)) begin
            hold_data_r <= data_r;
            hold_full_r <= 1'b1;
        end else if (pop_s) begin
            hold_data_r <= hold_data_r;
            hold_full_r <= 1'b0;
        end else begin
            hold_data_r <= hold_data_r;
            hold_full_r <= hold_full_r;
        end
    end

    assign head_s        = hold_data_r;
    assign full_s        = hold_full_r;
    assign empty_s       = !hold_full_r;
    assign count_field_s = {3'b000, hold_full_r};
`endif

    // Bus decode and next read data
    always_comb begin
        offset_s     = rx_addr[3:0];
        is_read_s    = rx_valid && (rx_wstrb == 4'h0);
        pop_s        = 1'b0;
        ctrl_wr_s    = 1'b0;
        rdata_next_s = 32'h0000_0000;
        if (is_read_s) begin
            case (offset_s)
                UART_RX_DATA_OFS: begin
                    if (!empty_s) begin
                        pop_s        = 1'b1;
                        rdata_next_s = {23'h0, 1'b1, head_s};
                    end else begin
                        rdata_next_s = 32'h0000_0000;
                    end
                end
                UART_RX_CTRL_OFS: begin
                    rdata_next_s = {24'h0, count_field_s, ferr_r, ovr_r, !empty_s, ie_r};
                end
                default: begin
                    rdata_next_s = 32'h0000_0000;
                end
            endcase
        end else begin
            ctrl_wr_s = rx_valid && (offset_s == UART_RX_CTRL_OFS) && rx_wstrb[0];
        end
        ovr_set_s = push_s && full_s && !pop_s;
    end

    // Bus response: ready and read data registered one cycle after the request
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rx_ready <= 1'b0;
            rx_rdata <= 32'h0000_0000;
        end else begin
            rx_ready <= rx_valid;
            rx_rdata <= rdata_next_s;
        end
    end

    // Control/status bits; a new error event wins over a same-cycle W1C
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ie_r   <= 1'b0;
            ovr_r  <= 1'b0;
            ferr_r <= 1'b0;
        end else begin
            if (ctrl_wr_s) begin
                ie_r <= rx_wdata[0];
            end else begin
                ie_r <= ie_r;
            end
            if (ovr_set_s) begin
                ovr_r <= 1'b1;
            end else if (ctrl_wr_s && rx_wdata[2]) begin
                ovr_r <= 1'b0;
            end else begin
                ovr_r <= ovr_r;
            end
            if (ferr_set_s) begin
                ferr_r <= 1'b1;
            end else if (ctrl_wr_s && rx_wdata[3]) begin
                ferr_r <= 1'b0;
            end else begin
                ferr_r <= ferr_r;
            end
        end
    end

    // Level interrupt while enabled and data is waiting
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rx_irq <= 1'b0;
        end else begin
            rx_irq <= ie_r && !empty_s;
        end
    end

endmodule

// File: tb/tb_uart_rx_port.sv
// Directed bench for uart_rx_port with CLK_DIV=8, DEPTH=4. Expected values
// are hand-derived; buffer depth follows UART_RX_FIFO_EN (4 or 1).
module tb_uart_rx_port;
    import configure::*;

    localparam int CLK_DIV = 8;
`ifdef UART_RX_FIFO_EN
    localparam int EFF_DEPTH = 4;
`else
    localparam int EFF_DEPTH = 1;
`endif
    localparam logic [31:0] DATA_ADDR = 32'h0100_0010;
    localparam logic [31:0] CTRL_ADDR = 32'h0100_0018;

    logic        reset;
    logic        clock;
    logic        rx_valid;
    logic [31:0] rx_addr;
    logic [31:0] rx_wdata;
    logic [3:0]  rx_wstrb;
    logic [31:0] rx_rdata;
    logic        rx_ready;
    logic        uart_rx;
    logic        rx_irq;

    int vec_cnt;
    int miscmp_cnt;

    uart_rx_port #(
        .CLK_DIV(CLK_DIV),
        .DEPTH  (4)
    ) dut (
        .reset    (reset),
        .clock    (clock),
        .rx_valid (rx_valid),
        .rx_addr  (rx_addr),
        .rx_wdata (rx_wdata),
        .rx_wstrb (rx_wstrb),
        .rx_rdata (rx_rdata),
        .rx_ready (rx_ready),
        .uart_rx  (uart_rx),
        .rx_irq   (rx_irq)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_vec(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec_cnt++;
        if (obs !== exp) begin
            miscmp_cnt++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic bus_read(input logic [31:0] addr, output logic [31:0] data);
        @(negedge clock);
        rx_valid = 1'b1;
        rx_addr  = addr;
        rx_wstrb = 4'h0;
        @(posedge clock);
        #1;
        data = rx_rdata;
        check_vec("rd_ready", 32'(rx_ready), 32'h1);
        rx_valid = 1'b0;
    endtask

    task automatic bus_write(input logic [31:0] addr, input logic [31:0] data);
        @(negedge clock);
        rx_valid = 1'b1;
        rx_addr  = addr;
        rx_wdata = data;
        rx_wstrb = 4'hF;
        @(posedge clock);
        #1;
        check_vec("wr_ready", 32'(rx_ready), 32'h1);
        rx_valid = 1'b0;
        rx_wstrb = 4'h0;
    endtask

    // Caller must be at a falling clock edge
    task automatic send_byte(input logic [7:0] b, input logic stop);
        uart_rx = 1'b0;
        repeat (CLK_DIV) @(negedge clock);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            repeat (CLK_DIV) @(negedge clock);
        end
        uart_rx = stop;
        repeat (CLK_DIV) @(negedge clock);
    endtask

    task automatic send_frame(input logic [7:0] b);
        @(negedge clock);
        send_byte(b, 1'b1);
        repeat (CLK_DIV) @(negedge clock);
    endtask

    initial begin
        logic [31:0] rd;
        vec_cnt    = 0;
        miscmp_cnt = 0;
        reset    = 1'b1;
        rx_valid = 1'b0;
        rx_addr  = 32'h0;
        rx_wdata = 32'h0;
        rx_wstrb = 4'h0;
        uart_rx  = 1'b1;

        // Reset values
        repeat (3) @(posedge clock);
        #1;
        check_vec("rst_irq", 32'(rx_irq), 32'h0);
        check_vec("rst_ready", 32'(rx_ready), 32'h0);
        check_vec("rst_rdata", rx_rdata, 32'h0);
        @(negedge clock);
        reset = 1'b0;
        bus_read(CTRL_ADDR, rd);
        check_vec("rst_status", rd, 32'h0);
        @(posedge clock);
        #1;
        check_vec("ready_drop", 32'(rx_ready), 32'h0);
        bus_read(DATA_ADDR + 32'h4, rd);
        check_vec("unmapped_rd", rd, 32'h0);

        // Basic receive
        send_frame(8'hA5);
        bus_read(DATA_ADDR, rd);
        check_vec("rx_a5", rd, 32'h0000_01A5);
        bus_read(DATA_ADDR, rd);
        check_vec("rx_empty", rd, 32'h0);
        check_vec("irq_off_ie0", 32'(rx_irq), 32'h0);

        // Interrupt timing: push at the 79th rising edge, irq at the 80th
        bus_write(CTRL_ADDR, 32'h1);
        bus_read(CTRL_ADDR, rd);
        check_vec("ie_set", rd, 32'h1);
        @(negedge clock);
        fork
            send_byte(8'h3C, 1'b1);
            begin
                repeat (79) @(posedge clock);
                #1;
                check_vec("irq_pre", 32'(rx_irq), 32'h0);
                @(posedge clock);
                #1;
                check_vec("irq_rise", 32'(rx_irq), 32'h1);
            end
        join
        bus_read(DATA_ADDR, rd);
        check_vec("rx_3c", rd, 32'h0000_013C);
        check_vec("irq_hold", 32'(rx_irq), 32'h1);
        @(posedge clock);
        #1;
        check_vec("irq_fall", 32'(rx_irq), 32'h0);

        // Overflow: five bytes, no reads
        bus_write(CTRL_ADDR, 32'h0);
        for (int i = 1; i <= 5; i++) begin
            send_frame(8'(i));
        end
        bus_read(CTRL_ADDR, rd);
        check_vec("ovr_status", rd, 32'((EFF_DEPTH << 4) | 6));
        for (int i = 1; i <= 5; i++) begin
            bus_read(DATA_ADDR, rd);
            check_vec("ovr_drain", rd, (i <= EFF_DEPTH) ? (32'h100 | 32'(i)) : 32'h0);
        end
        bus_read(CTRL_ADDR, rd);
        check_vec("ovr_only", rd, 32'h4);
        bus_write(CTRL_ADDR, 32'h4);
        bus_read(CTRL_ADDR, rd);
        check_vec("ovr_w1c", rd, 32'h0);

        // Framing error, then line held low for 20 bit times
        @(negedge clock);
        send_byte(8'hFF, 1'b0);
        repeat (20 * CLK_DIV) @(negedge clock);
        check_vec("wait_high", 32'(dut.state_r), 32'(WAIT_HIGH));
        bus_read(CTRL_ADDR, rd);
        check_vec("ferr_status", rd, 32'h8);
        uart_rx = 1'b1;
        repeat (2 * CLK_DIV) @(negedge clock);
        bus_read(DATA_ADDR, rd);
        check_vec("ferr_nopush", rd, 32'h0);
        bus_write(CTRL_ADDR, 32'h8);
        bus_read(CTRL_ADDR, rd);
        check_vec("ferr_w1c", rd, 32'h0);
        send_frame(8'h5A);
        bus_read(DATA_ADDR, rd);
        check_vec("rx_5a", rd, 32'h0000_015A);

        // Short glitch is a false start
        @(negedge clock);
        uart_rx = 1'b0;
        repeat (3) @(negedge clock);
        uart_rx = 1'b1;
        check_vec("glitch_start", 32'(dut.state_r), 32'(START));
        repeat (10) @(negedge clock);
        check_vec("glitch_idle", 32'(dut.state_r), 32'(IDLE));
        bus_read(CTRL_ADDR, rd);
        check_vec("glitch_empty", rd, 32'h0);

        // Reset in the middle of the data bits
        @(negedge clock);
        uart_rx = 1'b0;
        repeat (4 * CLK_DIV) @(negedge clock);
        check_vec("mid_data", 32'(dut.state_r), 32'(DATA));
        reset = 1'b1;
        #1;
        check_vec("mid_rst_idle", 32'(dut.state_r), 32'(IDLE));
        uart_rx = 1'b1;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        repeat (12 * CLK_DIV) @(negedge clock);
        bus_read(CTRL_ADDR, rd);
        check_vec("mid_rst_status", rd, 32'h0);
        bus_read(DATA_ADDR, rd);
        check_vec("mid_rst_nopush", rd, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscmp_cnt);
        $finish;
    end

endmodule
